// File: rtl/agc_pkg.sv
// Shared RX fixed-point definitions: loop state encoding, 1s17/U4.14 formats
// and the saturation / magnitude helpers used by the AGC.
package agc_pkg;

  typedef enum logic {
    ST_ACQUIRE = 1'b0,
    ST_TRACK   = 1'b1
  } agc_state_e;

  localparam int SAMPLE_W  = 18;
  localparam int GAIN_W    = 18;
  localparam int FRAC_BITS = 14;
  localparam int PROD_W    = SAMPLE_W + GAIN_W + 1;

  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 18'sh1FFFF;
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 18'sh20000;

  // Clip a wide signed product back into the 1s17 range.
  function automatic logic signed [SAMPLE_W-1:0] sat_sample(
    input logic signed [PROD_W-1:0] v
  );
    if (v > PROD_W'(SAMPLE_MAX)) begin
      return SAMPLE_MAX;
    end else if (v < PROD_W'(SAMPLE_MIN)) begin
      return SAMPLE_MIN;
    end else begin
      return v[SAMPLE_W-1:0];
    end
  endfunction

  // |x| with the single unrepresentable case folded onto full scale.
  function automatic logic [SAMPLE_W-1:0] magnitude(
    input logic signed [SAMPLE_W-1:0] x
  );
    if (x == SAMPLE_MIN) begin
      return SAMPLE_MAX;
    end else if (x[SAMPLE_W-1]) begin
      return -x;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/agc_power_det.sv
// Mean-magnitude detector: accumulates |y| over 2**LOG2_WIN symbol instants
// and flags the closing sample together with the window average.
module agc_power_det
  import agc_pkg::*;
#(
  parameter int LOG2_WIN = 5
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       meas_en,
  input  logic                       clear,
  input  logic signed [SAMPLE_W-1:0] y,
  output logic        [SAMPLE_W-1:0] avg,
  output logic                       win_done
);

  localparam int ACC_W = SAMPLE_W + LOG2_WIN;

  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [LOG2_WIN-1:0] win_cnt_q, win_cnt_d;
  logic [ACC_W-1:0]    acc_total;
  logic [SAMPLE_W-1:0] mag;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mag       = magnitude(y);
    acc_total = acc_q + {{LOG2_WIN{1'b0}}, mag};
    avg       = acc_total[LOG2_WIN +: SAMPLE_W];
    win_done  = meas_en && !clear && (win_cnt_q == '1);
    acc_d     = acc_q;
    win_cnt_d = win_cnt_q;

    // The closing sample is folded into avg above, then the window restarts.
    if (clear || win_done) begin
      acc_d     = '0;
      win_cnt_d = '0;
    end else if (meas_en) begin
      acc_d     = acc_total;
      win_cnt_d = win_cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= '0;
      win_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      win_cnt_q <= win_cnt_d;
    end
  end

endmodule

// File: rtl/rx_agc.sv
// Receiver AGC: scales the channel output by a U4.14 gain and closes the loop
// on the windowed mean magnitude, with a coarse acquire and a fine track mode.
module rx_agc
  import agc_pkg::*;
#(
  parameter int LOG2_WIN  = 5,
  parameter int REF       = 65536,
  parameter int TOL       = 2048,
  parameter int ACQ_STEP  = 1024,
  parameter int TRK_STEP  = 64,
  parameter int GAIN_INIT = 16384,
  parameter int GAIN_MIN  = 1024,
  parameter int GAIN_MAX  = 262143,
  parameter int LOCK_WINS = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sam_clk_ena,
  input  logic                       sym_clk_ena,
  input  logic                       hold,
  input  logic signed [SAMPLE_W-1:0] sig_in,
  output logic signed [SAMPLE_W-1:0] sig_out,
  output logic        [GAIN_W-1:0]   gain_out,
  output logic                       locked
);

  localparam int CNT_W = $clog2(LOCK_WINS + 1);

  localparam logic [SAMPLE_W-1:0] IN_HI    = SAMPLE_W'(REF + TOL);
  localparam logic [SAMPLE_W-1:0] IN_LO    = SAMPLE_W'(REF - TOL);
  localparam logic [SAMPLE_W-1:0] UNLK_HI  = SAMPLE_W'(REF + 4 * TOL);
  localparam logic [SAMPLE_W-1:0] UNLK_LO  = SAMPLE_W'(REF - 4 * TOL);
  localparam logic [GAIN_W:0]     STEP_ACQ = (GAIN_W + 1)'(ACQ_STEP);
  localparam logic [GAIN_W:0]     STEP_TRK = (GAIN_W + 1)'(TRK_STEP);
  localparam logic [GAIN_W:0]     G_MIN    = (GAIN_W + 1)'(GAIN_MIN);
  localparam logic [GAIN_W:0]     G_MAX    = (GAIN_W + 1)'(GAIN_MAX);

  agc_state_e                 state_q, state_d;
  logic [CNT_W-1:0]           inband_q, inband_d;
  logic [GAIN_W-1:0]          gain_q, gain_d;
  logic signed [SAMPLE_W-1:0] sig_out_q, sig_out_d;
  logic                       locked_q, locked_d;

  logic signed [PROD_W-1:0]   prod;
  logic signed [SAMPLE_W-1:0] y;
  logic [SAMPLE_W-1:0]        avg;
  logic                       win_done;

  // Datapath: signed sample times unsigned gain, back to 1s17.
  always_comb begin
    prod      = PROD_W'(sig_in) * PROD_W'($signed({1'b0, gain_q}));
    y         = sat_sample(prod >>> FRAC_BITS);
    sig_out_d = sam_clk_ena ? y : sig_out_q;
  end

  agc_power_det #(
    .LOG2_WIN (LOG2_WIN)
  ) u_power_det (
    .clk      (clk),
    .reset_n  (reset_n),
    .meas_en  (sym_clk_ena && sam_clk_ena),
    .clear    (hold),
    .y        (y),
    .avg      (avg),
    .win_done (win_done)
  );

  logic           too_high, too_low, in_band, far_off;
  logic [GAIN_W:0] step, gain_ext, gain_tgt;

  always_comb begin
    too_high = avg > IN_HI;
    too_low  = avg < IN_LO;
    in_band  = !too_high && !too_low;
    far_off  = (avg > UNLK_HI) || (avg < UNLK_LO);
    step     = (state_q == ST_TRACK) ? STEP_TRK : STEP_ACQ;
    gain_ext = {1'b0, gain_q};

    // 19-bit intermediate keeps the step from wrapping before the clamp.
    if (too_high) begin
      gain_tgt = (gain_ext > step) ? gain_ext - step : '0;
    end else if (too_low) begin
      gain_tgt = gain_ext + step;
    end else begin
      gain_tgt = gain_ext;
    end

    gain_d = gain_q;
    if (win_done) begin
      if (gain_tgt > G_MAX) begin
        gain_d = G_MAX[GAIN_W-1:0];
      end else if (gain_tgt < G_MIN) begin
        gain_d = G_MIN[GAIN_W-1:0];
      end else begin
        gain_d = gain_tgt[GAIN_W-1:0];
      end
    end
  end

  // Lock FSM: only window closes move it, so hold freezes it for free.
  always_comb begin
    state_d  = state_q;
    inband_d = inband_q;
    if (win_done) begin
      case (state_q)
        ST_ACQUIRE: begin
          if (!in_band) begin
            inband_d = '0;
          end else if (inband_q == CNT_W'(LOCK_WINS - 1)) begin
            state_d  = ST_TRACK;
            inband_d = '0;
          end else begin
            inband_d = inband_q + 1'b1;
          end
        end
        ST_TRACK: begin
          if (far_off) begin
            state_d = ST_ACQUIRE;
          end
        end
        default: begin
          state_d  = ST_ACQUIRE;
          inband_d = '0;
        end
      endcase
    end
    locked_d = (state_d == ST_TRACK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_ACQUIRE;
      inband_q  <= '0;
      gain_q    <= GAIN_W'(GAIN_INIT);
      sig_out_q <= '0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      inband_q  <= inband_d;
      gain_q    <= gain_d;
      sig_out_q <= sig_out_d;
      locked_q  <= locked_d;
    end
  end

  assign sig_out  = sig_out_q;
  assign gain_out = gain_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_rx_agc.sv
// Directed bench for rx_agc: reset, convergence, saturation, clamping, hold and relock
// scenarios with hand-computed gain, output and lock expectations.
module tb_rx_agc;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               sam_clk_ena;
  logic               sym_clk_ena;
  logic               hold;
  logic signed [17:0] sig_in;
  logic signed [17:0] sig_out;
  logic [17:0]        gain_out;
  logic               locked;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rx_agc dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sam_clk_ena (sam_clk_ena),
    .sym_clk_ena (sym_clk_ena),
    .hold        (hold),
    .sig_in      (sig_in),
    .sig_out     (sig_out),
    .gain_out    (gain_out),
    .locked      (locked)
  );

  task automatic apply_reset();
    reset_n     = 1'b0;
    sig_in      = '0;
    sam_clk_ena = 1'b0;
    sym_clk_ena = 1'b0;
    hold        = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Apply one clock of inputs; returns 1 time unit after the edge.
  task automatic drive(input logic signed [17:0] x, input logic sam, input logic sym,
                       input logic hld);
    sig_in      = x;
    sam_clk_ena = sam;
    sym_clk_ena = sym;
    hold        = hld;
    @(posedge clk);
    #1;
  endtask

  // n full windows, one symbol per clock; alt flips the sign every symbol.
  task automatic run_windows(input int n, input int amp, input bit alt);
    for (int w = 0; w < n; w++) begin
      for (int s = 0; s < 32; s++) begin
        drive(18'((alt && (s % 2 == 1)) ? -amp : amp), 1'b1, 1'b1, 1'b0);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    if (gain_out !== 18'(16384)) begin failures++; $display("FAIL rst_gain: got=%0d exp=%0d", gain_out, 16384); end
    checks++;
    if (locked !== 1'b0 || sig_out !== 18'(0)) begin failures++; $display("FAIL rst_out: locked=%0b sig_out=%0d exp 0/0", locked, sig_out); end
    checks++;
    drive(18'(32768), 1'b1, 1'b0, 1'b0);
    if (sig_out !== 18'(32768)) begin failures++; $display("FAIL unity_gain: got=%0d exp=%0d", sig_out, 32768); end
    checks++;
    run_windows(1, 0, 1'b0);
    drive(18'(1000), 1'b1, 1'b0, 1'b0);
    if (gain_out !== 18'(17408) || sig_out !== 18'(1062)) begin
      failures++; $display("FAIL pre_reset: gain=%0d sig_out=%0d exp 17408/1062", gain_out, sig_out);
    end
    checks++;
    #2 reset_n = 1'b0;
    #1;
    if (gain_out !== 18'(16384) || sig_out !== 18'(0) || locked !== 1'b0) begin
      failures++; $display("FAIL async_reset: gain=%0d sig_out=%0d locked=%0b exp 16384/0/0", gain_out, sig_out, locked);
    end
    checks++;
  endtask

  task automatic test_convergence();
    apply_reset();
    for (int w = 1; w <= 19; w++) begin
      for (int s = 0; s < 32; s++) begin
        drive(18'((s % 2 == 1) ? -32768 : 32768), 1'b1, 1'b1, 1'b0);
        repeat (3) drive(18'((s % 2 == 1) ? -32768 : 32768), 1'b1, 1'b0, 1'b0);
      end
      if (w == 15) begin
        if (gain_out !== 18'(31744) || locked !== 1'b0) begin
          failures++; $display("FAIL conv_w15: gain=%0d locked=%0b exp 31744/0", gain_out, locked);
        end
        checks++;
      end
      if (w == 18) begin
        if (locked !== 1'b0) begin failures++; $display("FAIL conv_w18_locked: got=%0b exp=0", locked); end
        checks++;
      end
    end
    if (gain_out !== 18'(31744) || locked !== 1'b1) begin
      failures++; $display("FAIL conv_lock: gain=%0d locked=%0b exp 31744/1", gain_out, locked);
    end
    checks++;
    drive(18'(32768), 1'b1, 1'b0, 1'b0);
    if (sig_out !== 18'(63488)) begin failures++; $display("FAIL conv_level: got=%0d exp=%0d", sig_out, 63488); end
    checks++;
    run_windows(2, 32768, 1'b1);
    if (gain_out !== 18'(31744) || locked !== 1'b1) begin
      failures++; $display("FAIL conv_track_steady: gain=%0d locked=%0b exp 31744/1", gain_out, locked);
    end
    checks++;
  endtask

  task automatic test_saturation();
    apply_reset();
    run_windows(48, 0, 1'b0);
    if (gain_out !== 18'(65536)) begin failures++; $display("FAIL sat_gain: got=%0d exp=%0d", gain_out, 65536); end
    checks++;
    drive(18'(131071), 1'b1, 1'b0, 1'b0);
    if (sig_out !== 18'(131071)) begin failures++; $display("FAIL sat_pos: got=%0d exp=%0d", sig_out, 131071); end
    checks++;
    drive(18'(-131072), 1'b1, 1'b0, 1'b0);
    if (sig_out !== 18'(-131072)) begin failures++; $display("FAIL sat_neg: got=%0d exp=%0d", sig_out, -131072); end
    checks++;
    drive(18'(1000), 1'b1, 1'b0, 1'b0);
    if (sig_out !== 18'(4000)) begin failures++; $display("FAIL gain4_pos: got=%0d exp=%0d", sig_out, 4000); end
    checks++;
    drive(18'(-1000), 1'b1, 1'b0, 1'b0);
    drive(18'(5000), 1'b0, 1'b0, 1'b0);
    if (sig_out !== 18'(-4000)) begin failures++; $display("FAIL sam_hold: got=%0d exp=%0d", sig_out, -4000); end
    checks++;
    run_windows(1, -131072, 1'b0);
    if (gain_out !== 18'(64512) || locked !== 1'b0) begin
      failures++; $display("FAIL sat_window_step: gain=%0d locked=%0b exp 64512/0", gain_out, locked);
    end
    checks++;
  endtask

  task automatic test_clamp();
    apply_reset();
    run_windows(239, 0, 1'b0);
    if (gain_out !== 18'(261120)) begin failures++; $display("FAIL clamp_pre: got=%0d exp=%0d", gain_out, 261120); end
    checks++;
    run_windows(1, 0, 1'b0);
    if (gain_out !== 18'(262143)) begin failures++; $display("FAIL clamp_max: got=%0d exp=%0d", gain_out, 262143); end
    checks++;
    run_windows(10, 0, 1'b0);
    if (gain_out !== 18'(262143)) begin failures++; $display("FAIL clamp_no_wrap: got=%0d exp=%0d", gain_out, 262143); end
    checks++;
    apply_reset();
    run_windows(8, 131071, 1'b0);
    if (gain_out !== 18'(8192) || locked !== 1'b0) begin
      failures++; $display("FAIL down_settle: gain=%0d locked=%0b exp 8192/0", gain_out, locked);
    end
    checks++;
    run_windows(3, 131071, 1'b0);
    if (gain_out !== 18'(8192) || locked !== 1'b0) begin
      failures++; $display("FAIL down_prelock: gain=%0d locked=%0b exp 8192/0", gain_out, locked);
    end
    checks++;
    run_windows(1, 131071, 1'b0);
    if (gain_out !== 18'(8192) || locked !== 1'b1) begin
      failures++; $display("FAIL down_lock: gain=%0d locked=%0b exp 8192/1", gain_out, locked);
    end
    checks++;
  endtask

  task automatic test_hold();
    apply_reset();
    repeat (17) drive(18'(0), 1'b1, 1'b1, 1'b0);
    repeat (50) drive(18'(0), 1'b1, 1'b1, 1'b1);
    if (gain_out !== 18'(16384)) begin failures++; $display("FAIL hold_frozen: got=%0d exp=%0d", gain_out, 16384); end
    checks++;
    repeat (10) drive(18'(0), 1'b0, 1'b1, 1'b0);
    repeat (31) drive(18'(0), 1'b1, 1'b1, 1'b0);
    if (gain_out !== 18'(16384)) begin failures++; $display("FAIL hold_release_31: got=%0d exp=%0d", gain_out, 16384); end
    checks++;
    drive(18'(0), 1'b1, 1'b1, 1'b0);
    if (gain_out !== 18'(17408)) begin failures++; $display("FAIL hold_release_32: got=%0d exp=%0d", gain_out, 17408); end
    checks++;
    repeat (31) drive(18'(0), 1'b1, 1'b1, 1'b0);
    drive(18'(0), 1'b1, 1'b1, 1'b1);
    if (gain_out !== 18'(17408)) begin failures++; $display("FAIL hold_on_close: got=%0d exp=%0d", gain_out, 17408); end
    checks++;
    repeat (31) drive(18'(0), 1'b1, 1'b1, 1'b0);
    if (gain_out !== 18'(17408)) begin failures++; $display("FAIL hold_close_restart: got=%0d exp=%0d", gain_out, 17408); end
    checks++;
    drive(18'(0), 1'b1, 1'b1, 1'b0);
    if (gain_out !== 18'(18432)) begin failures++; $display("FAIL hold_close_next: got=%0d exp=%0d", gain_out, 18432); end
    checks++;
  endtask

  task automatic test_relock();
    apply_reset();
    run_windows(46, 16384, 1'b1);
    if (gain_out !== 18'(63488) || locked !== 1'b0) begin
      failures++; $display("FAIL relock_acq: gain=%0d locked=%0b exp 63488/0", gain_out, locked);
    end
    checks++;
    run_windows(3, 16384, 1'b1);
    if (locked !== 1'b0) begin failures++; $display("FAIL relock_prelock: got=%0b exp=0", locked); end
    checks++;
    run_windows(1, 16384, 1'b1);
    if (gain_out !== 18'(63488) || locked !== 1'b1) begin
      failures++; $display("FAIL relock_lock1: gain=%0d locked=%0b exp 63488/1", gain_out, locked);
    end
    checks++;
    run_windows(1, 65536, 1'b1);
    if (gain_out !== 18'(63424) || locked !== 1'b0) begin
      failures++; $display("FAIL relock_unlock: gain=%0d locked=%0b exp 63424/0", gain_out, locked);
    end
    checks++;
    run_windows(46, 65536, 1'b1);
    if (gain_out !== 18'(16320) || locked !== 1'b0) begin
      failures++; $display("FAIL relock_reacq: gain=%0d locked=%0b exp 16320/0", gain_out, locked);
    end
    checks++;
    run_windows(3, 65536, 1'b1);
    if (locked !== 1'b0) begin failures++; $display("FAIL relock_prelock2: got=%0b exp=0", locked); end
    checks++;
    run_windows(1, 65536, 1'b1);
    if (gain_out !== 18'(16320) || locked !== 1'b1) begin
      failures++; $display("FAIL relock_lock2: gain=%0d locked=%0b exp 16320/1", gain_out, locked);
    end
    checks++;
  endtask

  initial begin
    reset_n     = 1'b0;
    sig_in      = '0;
    sam_clk_ena = 1'b0;
    sym_clk_ena = 1'b0;
    hold        = 1'b0;
    test_reset();
    test_convergence();
    test_saturation();
    test_clamp();
    test_hold();
    test_relock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
